// File: rtl/usbfs_tx_arbiter.sv
// Round-robin arbiter that shares one USB full-speed packet sender between N_REQ requesters.
// The grant is held through the sender's EOP, then a fixed idle gap runs before the next offer.
module usbfs_tx_arbiter #(
    parameter int N_REQ      = 4,
    parameter int MAX_PKT    = 8,
    parameter int GAP_CYCLES = 2,
    localparam int NB_W      = $clog2(MAX_PKT) + 1
) (
    input  logic                         i_clk_12MHz,
    input  logic                         i_rst,
    input  logic [N_REQ-1:0]             i_req_valid,
    output logic [N_REQ-1:0]             o_req_ready,
    input  logic [4*N_REQ-1:0]           i_req_pid,
    input  logic [8*MAX_PKT*N_REQ-1:0]   i_req_data,
    input  logic [NB_W*N_REQ-1:0]        i_req_nBytes,
    output logic                         o_tx_valid,
    input  logic                         i_tx_ready,
    output logic [3:0]                   o_tx_pid,
    output logic [8*MAX_PKT-1:0]         o_tx_data,
    output logic [NB_W-1:0]              o_tx_nBytes,
    input  logic                         i_tx_eopDone,
    output logic [N_REQ-1:0]             o_grant,
    output logic                         o_busy,
    output logic [15:0]                  o_nSent
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int PKT_W = 8 * MAX_PKT;

    typedef enum logic [1:0] {ST_IDLE, ST_OFFER, ST_WAIT_EOP, ST_GAP} state_t;

    state_t             r_state, w_state_nxt;
    logic [N_REQ-1:0]   r_grant, w_grant_nxt;
    logic [IDX_W-1:0]   r_rrPtr, w_rrPtr_nxt;
    logic [7:0]         r_gapCnt, w_gapCnt_nxt;
    logic [15:0]        r_nSent;
    logic [IDX_W-1:0]   w_selIdx, w_cand, w_ptrAfter;
    logic               w_selFound;
    logic               w_accept;

    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        return IDX_W'(v % N_REQ);
    endfunction

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        w_selFound = 1'b0;
        w_selIdx   = '0;
        w_cand     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_cand = wrap_idx(int'(r_rrPtr) + i);
            if (!w_selFound && i_req_valid[w_cand]) begin
                w_selFound = 1'b1;
                w_selIdx   = w_cand;
            end
        end
    end

    // One-hot OR-mux of the granted requester; fields read as zero unless offering.
    always_comb begin
        o_tx_pid    = '0;
        o_tx_data   = '0;
        o_tx_nBytes = '0;
        w_ptrAfter  = r_rrPtr;
        for (int k = 0; k < N_REQ; k++) begin
            if (r_grant[k]) begin
                w_ptrAfter = wrap_idx(k + 1);
                if (r_state == ST_OFFER) begin
                    o_tx_pid    = o_tx_pid    | i_req_pid[4*k +: 4];
                    o_tx_data   = o_tx_data   | i_req_data[PKT_W*k +: PKT_W];
                    o_tx_nBytes = o_tx_nBytes | i_req_nBytes[NB_W*k +: NB_W];
                end
            end
        end
    end

    assign w_accept = (r_state == ST_OFFER) && i_tx_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rrPtr_nxt  = r_rrPtr;
        w_gapCnt_nxt = r_gapCnt;
        case (r_state)
            ST_IDLE: begin
                if (w_selFound) begin
                    w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_selIdx;
                    w_state_nxt = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (i_tx_ready) begin
                    w_rrPtr_nxt = w_ptrAfter;
                    w_state_nxt = ST_WAIT_EOP;
                end
            end
            ST_WAIT_EOP: begin
                if (i_tx_eopDone) begin
                    w_grant_nxt = '0;
                    if (GAP_CYCLES == 0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_gapCnt_nxt = 8'(GAP_CYCLES - 1);
                        w_state_nxt  = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (r_gapCnt == 8'd0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_gapCnt_nxt = r_gapCnt - 8'd1;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_12MHz) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rrPtr  <= '0;
            r_gapCnt <= '0;
            r_nSent  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rrPtr  <= w_rrPtr_nxt;
            r_gapCnt <= w_gapCnt_nxt;
            r_nSent  <= r_nSent + 16'(w_accept);
        end
    end

    assign o_tx_valid  = (r_state == ST_OFFER);
    assign o_req_ready = r_grant & {N_REQ{w_accept}};
    assign o_grant     = r_grant;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_nSent     = r_nSent;

    // A granted requester must keep its packet valid until the sender takes it.
    a_validHeld: assert property (@(posedge i_clk_12MHz) disable iff (i_rst)
        (r_state == ST_OFFER) |-> |(i_req_valid & r_grant));

endmodule

// File: tb/tb_usbfs_tx_arbiter.sv
// Directed bench for usbfs_tx_arbiter: one instance with GAP_CYCLES=2, one with GAP_CYCLES=0.
module tb_usbfs_tx_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, tx_ready, eop, tx_valid, busy;
    logic [3:0]   req_valid, req_ready, tx_pid, tx_nb, grant;
    logic [15:0]  req_pid, req_nb, nsent;
    logic [255:0] req_data;
    logic [63:0]  tx_data;

    logic         z_rst, z_tx_ready, z_eop, z_tx_valid, z_busy;
    logic [3:0]   z_req_valid, z_req_ready, z_tx_pid, z_tx_nb, z_grant;
    logic [15:0]  z_req_pid, z_req_nb, z_nsent;
    logic [255:0] z_req_data;
    logic [63:0]  z_tx_data;

    int checks = 0;
    int failures = 0;

    usbfs_tx_arbiter #(.N_REQ(4), .MAX_PKT(8), .GAP_CYCLES(2)) dut (
        .i_clk_12MHz(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_pid(req_pid), .i_req_data(req_data), .i_req_nBytes(req_nb),
        .o_tx_valid(tx_valid), .i_tx_ready(tx_ready), .o_tx_pid(tx_pid), .o_tx_data(tx_data),
        .o_tx_nBytes(tx_nb), .i_tx_eopDone(eop), .o_grant(grant), .o_busy(busy), .o_nSent(nsent)
    );

    usbfs_tx_arbiter #(.N_REQ(4), .MAX_PKT(8), .GAP_CYCLES(0)) dut0 (
        .i_clk_12MHz(clk), .i_rst(z_rst), .i_req_valid(z_req_valid), .o_req_ready(z_req_ready),
        .i_req_pid(z_req_pid), .i_req_data(z_req_data), .i_req_nBytes(z_req_nb),
        .o_tx_valid(z_tx_valid), .i_tx_ready(z_tx_ready), .o_tx_pid(z_tx_pid), .o_tx_data(z_tx_data),
        .o_tx_nBytes(z_tx_nb), .i_tx_eopDone(z_eop), .o_grant(z_grant), .o_busy(z_busy), .o_nSent(z_nsent)
    );

    task automatic set_req(input int k, input logic [3:0] pid, input logic [63:0] data, input logic [3:0] nb);
        req_pid[4*k +: 4]   = pid;
        req_data[64*k +: 64] = data;
        req_nb[4*k +: 4]    = nb;
    endtask

    // Steps negedges until the chosen instance offers a packet, up to a bound.
    task automatic wait_offer(input bit which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if ((which ? z_tx_valid : tx_valid) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Called in WAIT_EOP at a negedge; returns at the negedge where the GAP_CYCLES=2 instance is IDLE again.
    task automatic finish_pkt();
        eop = 1'b1;
        @(negedge clk);
        eop = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; z_rst = 1'b1;
        req_valid = '0; req_pid = '0; req_data = '0; req_nb = '0; tx_ready = 1'b0; eop = 1'b0;
        z_req_valid = '0; z_req_pid = '0; z_req_data = '0; z_req_nb = '0; z_tx_ready = 1'b0; z_eop = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_txvalid got=%b exp=0", tx_valid); end
        checks++; if (req_ready !== 4'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant !== 4'b0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (nsent !== 16'h0) begin failures++; $display("FAIL reset_nsent got=%h exp=0000", nsent); end
        checks++; if (z_busy !== 1'b0) begin failures++; $display("FAIL reset_z_busy got=%b exp=0", z_busy); end
        rst = 1'b0; z_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        set_req(2, 4'b0011, 64'h0000_0000_00CC_BBAA, 4'd3);
        req_valid = 4'b0100;
        tx_ready = 1'b1;
        #1;
        checks++; if (tx_valid !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL single_idle got valid=%b ready=%b exp valid=0 ready=0000", tx_valid, req_ready); end
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1) begin failures++; $display("FAIL single_latency got=%b exp=1", tx_valid); end
        checks++; if (tx_pid !== 4'b0011) begin failures++; $display("FAIL single_pid got=%h exp=3", tx_pid); end
        checks++; if (tx_data !== 64'h0000_0000_00CC_BBAA) begin failures++; $display("FAIL single_data got=%h exp=0000000000ccbbaa", tx_data); end
        checks++; if (tx_nb !== 4'd3) begin failures++; $display("FAIL single_nbytes got=%0d exp=3", tx_nb); end
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        checks++; if (grant !== 4'b0100) begin failures++; $display("FAIL single_grant got=%b exp=0100", grant); end
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (tx_valid !== 1'b0 || req_ready !== 4'b0) begin failures++; $display("FAIL single_after_accept got valid=%b ready=%b exp 0/0000", tx_valid, req_ready); end
        checks++; if (nsent !== 16'd1) begin failures++; $display("FAIL single_nsent got=%0d exp=1", nsent); end
        checks++; if (grant !== 4'b0100 || busy !== 1'b1) begin failures++; $display("FAIL single_waiteop got grant=%b busy=%b exp 0100/1", grant, busy); end
        checks++; if (tx_pid !== 4'h0 || tx_data !== 64'h0 || tx_nb !== 4'h0) begin failures++; $display("FAIL single_fields_zero got pid=%h nb=%h exp 0", tx_pid, tx_nb); end
        finish_pkt();
        checks++; if (busy !== 1'b0 || grant !== 4'b0) begin failures++; $display("FAIL single_idle_again got busy=%b grant=%b exp 0/0000", busy, grant); end
    endtask

    task automatic test_round_robin();
        int exp_order [6] = '{0, 1, 3, 0, 1, 3};
        logic [3:0] pid_of [4] = '{4'h1, 4'h2, 4'h0, 4'h4};
        int cnt [4] = '{0, 0, 0, 0};
        bit ok;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 4'h1, 64'h10, 4'd1);
        set_req(1, 4'h2, 64'h2020, 4'd2);
        set_req(3, 4'h4, 64'h4040_4040, 4'd4);
        req_valid = 4'b1011;
        tx_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            wait_offer(1'b0, ok);
            checks++; if (!ok) begin failures++; $display("FAIL rr_timeout pkt=%0d got no offer exp offer", p); end
            checks++; if (grant !== (4'b0001 << exp_order[p])) begin failures++; $display("FAIL rr_grant pkt=%0d got=%b exp=%b", p, grant, 4'b0001 << exp_order[p]); end
            checks++; if (tx_pid !== pid_of[exp_order[p]]) begin failures++; $display("FAIL rr_pid pkt=%0d got=%h exp=%h", p, tx_pid, pid_of[exp_order[p]]); end
            checks++; if (req_ready !== grant) begin failures++; $display("FAIL rr_ready pkt=%0d got=%b exp=%b", p, req_ready, grant); end
            for (int k = 0; k < 4; k++) if (grant[k] === 1'b1) cnt[k]++;
            @(negedge clk);
            finish_pkt();
        end
        req_valid = 4'b0000;
        checks++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 0 || cnt[3] != 2) begin failures++; $display("FAIL rr_fairness got=%0d,%0d,%0d,%0d exp=2,2,0,2", cnt[0], cnt[1], cnt[2], cnt[3]); end
        checks++; if (nsent !== 16'd6) begin failures++; $display("FAIL rr_nsent got=%0d exp=6", nsent); end
    endtask

    task automatic test_stall();
        bit ok;
        set_req(0, 4'hA, 64'h1122_3344_5566_7788, 4'd8);
        tx_ready = 1'b0;
        req_valid = 4'b0001;
        wait_offer(1'b0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got no offer exp offer"); end
        for (int i = 0; i < 10; i++) begin
            checks++; if (grant !== 4'b0001 || req_ready !== 4'b0000) begin failures++; $display("FAIL stall_hold cyc=%0d got grant=%b ready=%b exp 0001/0000", i, grant, req_ready); end
            checks++; if (tx_pid !== 4'hA || tx_data !== 64'h1122_3344_5566_7788 || tx_nb !== 4'd8) begin failures++; $display("FAIL stall_fields cyc=%0d got pid=%h data=%h nb=%0d exp a/1122334455667788/8", i, tx_pid, tx_data, tx_nb); end
            if (i == 3) req_valid[1] = 1'b1;
            @(negedge clk);
        end
        tx_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL stall_release_ready got=%b exp=0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        checks++; if (tx_valid !== 1'b0 || nsent !== 16'd7) begin failures++; $display("FAIL stall_accept got valid=%b nsent=%0d exp 0/7", tx_valid, nsent); end
        finish_pkt();
        wait_offer(1'b0, ok);
        checks++; if (!ok || grant !== 4'b0010) begin failures++; $display("FAIL stall_next_grant got=%b exp=0010", grant); end
        @(negedge clk);
        req_valid = 4'b0000;
        finish_pkt();
    endtask

    task automatic test_gap();
        bit ok;
        set_req(2, 4'h3, 64'h22, 4'd1);
        set_req(3, 4'hB, 64'h33, 4'd1);
        tx_ready = 1'b1;
        req_valid = 4'b0100;
        wait_offer(1'b0, ok);
        checks++; if (!ok || grant !== 4'b0100) begin failures++; $display("FAIL gap_first_grant got=%b exp=0100", grant); end
        @(negedge clk);
        req_valid = 4'b1000;
        eop = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            eop = 1'b0;
            checks++; if (tx_valid !== (k == 4)) begin failures++; $display("FAIL gap2_valid k=%0d got=%b exp=%b", k, tx_valid, (k == 4)); end
            if (k == 2) begin
                checks++; if (grant !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL gap2_state got grant=%b busy=%b exp 0000/1", grant, busy); end
            end
        end
        checks++; if (grant !== 4'b1000) begin failures++; $display("FAIL gap2_next_grant got=%b exp=1000", grant); end
        @(negedge clk);
        req_valid = 4'b0000;
        finish_pkt();
    endtask

    task automatic test_gap_zero();
        bit ok;
        z_req_pid = 16'h0C30; z_req_data = '0; z_req_nb = 16'h0110;
        z_tx_ready = 1'b1;
        z_req_valid = 4'b0010;
        wait_offer(1'b1, ok);
        checks++; if (!ok || z_grant !== 4'b0010) begin failures++; $display("FAIL gap0_first_grant got=%b exp=0010", z_grant); end
        @(negedge clk);
        z_req_valid = 4'b0100;
        z_eop = 1'b1;
        @(negedge clk);
        z_eop = 1'b0;
        checks++; if (z_tx_valid !== 1'b0 || z_busy !== 1'b0) begin failures++; $display("FAIL gap0_idle got valid=%b busy=%b exp 0/0", z_tx_valid, z_busy); end
        @(negedge clk);
        checks++; if (z_tx_valid !== 1'b1 || z_grant !== 4'b0100) begin failures++; $display("FAIL gap0_next_offer got valid=%b grant=%b exp 1/0100", z_tx_valid, z_grant); end
        checks++; if (z_tx_pid !== 4'hC) begin failures++; $display("FAIL gap0_pid got=%h exp=c", z_tx_pid); end
        @(negedge clk);
        z_req_valid = 4'b0000;
        z_eop = 1'b1;
        @(negedge clk);
        z_eop = 1'b0;
        checks++; if (z_nsent !== 16'd2) begin failures++; $display("FAIL gap0_nsent got=%0d exp=2", z_nsent); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        set_req(0, 4'h5, 64'h55, 4'd1);
        tx_ready = 1'b1;
        req_valid = 4'b0001;
        wait_offer(1'b0, ok);
        @(negedge clk);
        req_valid = 4'b0101;
        checks++; if (!ok || busy !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL rstmid_pre got busy=%b grant=%b exp 1/0001", busy, grant); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b0 || req_ready !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_ctrl got valid=%b ready=%b grant=%b busy=%b exp all 0", tx_valid, req_ready, grant, busy); end
        checks++; if (nsent !== 16'd0 || tx_pid !== 4'h0 || tx_data !== 64'h0 || tx_nb !== 4'h0) begin failures++; $display("FAIL rstmid_data got nsent=%0d pid=%h nb=%h exp 0", nsent, tx_pid, tx_nb); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (tx_valid !== 1'b1 || grant !== 4'b0001) begin failures++; $display("FAIL rstmid_ptr got valid=%b grant=%b exp 1/0001", tx_valid, grant); end
        @(negedge clk);
        req_valid = 4'b0000;
        finish_pkt();
    endtask

    task automatic test_wrap();
        bit ok;
        force dut.r_nSent = 16'hFFFF;
        @(negedge clk);
        release dut.r_nSent;
        checks++; if (nsent !== 16'hFFFF) begin failures++; $display("FAIL wrap_preset got=%h exp=ffff", nsent); end
        tx_ready = 1'b1;
        req_valid = 4'b0010;
        wait_offer(1'b0, ok);
        @(negedge clk);
        req_valid = 4'b0000;
        checks++; if (!ok || nsent !== 16'h0000) begin failures++; $display("FAIL wrap_nsent got=%h exp=0000", nsent); end
        finish_pkt();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_gap();
        test_gap_zero();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule

// File: doc/usbfs_tx_arbiter.md
# usbfs_tx_arbiter

Round-robin arbiter sharing one USB full-speed packet sender between `N_REQ` requesters (e.g. handshake responder, endpoint IN handlers, host token scheduler). It sits between the requesters and the sender's valid/ready packet interface on the 12MHz domain. It holds a grant until the sender accepts the packet and waits for end-of-packet. It then enforces a minimum inter-packet gap before offering the next packet.

## Interface
- `N_REQ`, 4, number of requesters (2..8).
- `MAX_PKT`, 8, max data bytes per packet; matches the sender.
- `GAP_CYCLES`, 2, idle 12MHz cycles inserted after `i_tx_eopDone` (0..255).
- `NB_W` (localparam) = $clog2(MAX_PKT)+1.
- `i_clk_12MHz  in  1  sole clock; all logic on the rising edge.`
- `i_rst  in  1  reset, synchronous, active-high.`
- `i_req_valid  in  N_REQ  per-requester packet valid; held until the matching ready.`
- `o_req_ready  out  N_REQ  per-requester accept; at most one bit set.`
- `i_req_pid  in  4*N_REQ  PID, requester k at [4k+:4].`
- `i_req_data  in  8*MAX_PKT*N_REQ  payload, requester k at [8*MAX_PKT*k +: 8*MAX_PKT], byte 0 in the LSBs.`
- `i_req_nBytes  in  NB_W*N_REQ  payload length, 0..MAX_PKT.`
- `o_tx_valid  out  1  packet offered to the sender.`
- `i_tx_ready  in  1  sender accept.`
- `o_tx_pid  out  4  muxed PID.`
- `o_tx_data  out  8*MAX_PKT  muxed payload.`
- `o_tx_nBytes  out  NB_W  muxed length.`
- `i_tx_eopDone  in  1  single-cycle pulse when the sender finishes EOP.`
- `o_grant  out  N_REQ  one-hot current grant; 0 when none.`
- `o_busy  out  1  state != IDLE.`
- `o_nSent  out  16  count of packets accepted by the sender; wraps.`

## Operation
- FSM states: IDLE, OFFER, WAIT_EOP, GAP.
- IDLE, with any `i_req_valid` set:
  - Select the first valid index at or after `rrPtr_q`, searching upward modulo N_REQ.
  - Register the selection into `grant_q` (one-hot).
  - Next state OFFER.
- OFFER:
  - `o_tx_valid`=1.
  - `o_tx_pid`, `o_tx_data` and `o_tx_nBytes` are a combinational mux of the granted requester's inputs.
  - `o_req_ready` = `grant_q` & {N_REQ{`i_tx_ready`}}.
  - On `i_tx_ready`:
    - `rrPtr_q` is set to granted index + 1, modulo N_REQ.
    - `o_nSent` increments.
    - Next state WAIT_EOP.
  - The grant is never withdrawn in OFFER, even if another requester asserts valid.
  - Dropping valid while granted is a requester protocol violation; an assertion covers it. The arbiter keeps offering regardless.
- WAIT_EOP:
  - `o_tx_valid`=0 and `o_grant` is still held.
  - On `i_tx_eopDone`:
    - If GAP_CYCLES=0, go to IDLE.
    - Otherwise load `gapCnt_q` with GAP_CYCLES-1 and go to GAP.
- GAP:
  - `o_grant`=0.
  - `gapCnt_q` decrements each cycle; when it is 0, the next state is IDLE.
  - Requests are ignored until IDLE.
- Outside OFFER, `o_tx_pid`, `o_tx_data` and `o_tx_nBytes` drive 0.
- `i_tx_eopDone` outside WAIT_EOP is ignored.
- `i_tx_ready` outside OFFER is ignored.
- Reset:
  - Applies in any state, including mid-packet.
  - State goes to IDLE; `rrPtr_q`=0, `grant_q`=0, `gapCnt_q`=0, `o_nSent`=0.
  - `o_tx_valid`=0, `o_req_ready`=0, `o_busy`=0.
  - No pending request survives reset; requesters re-present after reset.

## Timing
- Request latency: `i_req_valid` seen in IDLE at edge t gives `o_tx_valid`=1 from cycle t+1.
- Accept cycle: `o_req_ready` and `i_tx_ready` are coincident, combinational from `i_tx_ready`.
- Accept at edge t+n gives state WAIT_EOP and `o_nSent`+1 from cycle t+n+1.
- EOP recovery: `i_tx_eopDone` at edge e gives GAP at e+1. IDLE is reached at e+1+GAP_CYCLES.
- Earliest next offer is at e+2+GAP_CYCLES. With GAP_CYCLES=0, IDLE is at e+1 and the next offer at e+2.
- Fairness: under continuous requests from all requesters, each is served exactly once per N_REQ packets.
- `o_nSent` wraps from 16'hFFFF to 0.

## Test plan
- Single requester:
  - Stimulus: requester 2 valid with PID=DATA0 (4'b0011), nBytes=3, data=0x0000_0000_00CC_BBAA; sender ready stuck at 1.
  - Response: `o_tx_valid` one cycle after valid; fields match; `o_req_ready`=4'b0100 for exactly one cycle; `o_nSent`=1.
- Round-robin:
  - Stimulus: requesters 0, 1 and 3 continuously valid.
  - Response: accepted order 0,1,3,0,1,3; with N_REQ=4 each index appears 2 times in 6 packets.
- Sender stall:
  - Stimulus: `i_tx_ready` low for 10 cycles during OFFER; requester 1 raises valid mid-stall.
  - Response: grant stays on the original requester; fields are stable; no `o_req_ready` until ready rises.
- Gap enforcement:
  - Stimulus: GAP_CYCLES=2, eopDone at edge e, another request pending.
  - Response: next `o_tx_valid` rises exactly at cycle e+4.
  - Repeat with GAP_CYCLES=0: next `o_tx_valid` at e+2.
- Reset mid-operation:
  - Stimulus: assert `i_rst` for one cycle in WAIT_EOP.
  - Response: next cycle all outputs 0, state IDLE; the following grant is the lowest valid index (pointer 0).
- Counter wrap:
  - Stimulus: force `o_nSent`=16'hFFFF, then one accept.
  - Response: `o_nSent`=0.
